// File: rtl/alu_exec_pkg.sv
// Shared encodings for the execute stage: control-unit opcodes, decoded ALU
// operations, funct codes and REGIMM rt selectors.
package alu_exec_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_RTYPE  = 4'd2,
        OP_BNE    = 4'd3,
        OP_AND    = 4'd4,
        OP_OR     = 4'd5,
        OP_XOR    = 4'd6,
        OP_SLT    = 4'd7,
        OP_SLTU   = 4'd8,
        OP_BLEZ   = 4'd9,
        OP_BGTZ   = 4'd10,
        OP_REGIMM = 4'd11,
        OP_LUI    = 4'd12
    } alu_op_e;

    typedef enum logic [4:0] {
        C_ADD  = 5'd0,
        C_SUB  = 5'd1,
        C_AND  = 5'd2,
        C_OR   = 5'd3,
        C_XOR  = 5'd4,
        C_NOR  = 5'd5,
        C_SLT  = 5'd6,
        C_SLTU = 5'd7,
        C_SLL  = 5'd8,
        C_SRL  = 5'd9,
        C_SRA  = 5'd10,
        C_SLLV = 5'd11,
        C_SRLV = 5'd12,
        C_SRAV = 5'd13,
        C_BNE  = 5'd14,
        C_BLEZ = 5'd15,
        C_BGTZ = 5'd16,
        C_BLTZ = 5'd17,
        C_BGEZ = 5'd18,
        C_LUI  = 5'd19,
        C_ADDS = 5'd20,
        C_SUBS = 5'd21
    } alu_ctrl_e;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_SRAV = 6'h07;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    localparam logic [4:0] RT_BLTZ   = 5'b00000;
    localparam logic [4:0] RT_BLTZAL = 5'b10000;
    localparam logic [4:0] RT_BGEZ   = 5'b00001;
    localparam logic [4:0] RT_BGEZAL = 5'b10001;

endpackage

// File: rtl/alu_decode.sv
// Combinational decode of alu_op / funct / rt_field into the ALU control code.
// ALU_OVERFLOW_EN: funct ADD/SUB decode to the overflow-checking ADDS/SUBS.
module alu_decode
    import alu_exec_pkg::*;
(
    input  logic [3:0] alu_op,
    input  logic [5:0] funct,
    input  logic [4:0] rt_field,
    output logic [4:0] alu_ctrl
);

    alu_ctrl_e funct_ctrl;
    alu_ctrl_e regimm_ctrl;
    alu_ctrl_e ctrl;

    always_comb begin
        funct_ctrl = C_ADD;
        case (funct)
            F_SLL:  funct_ctrl = C_SLL;
            F_SRL:  funct_ctrl = C_SRL;
            F_SRA:  funct_ctrl = C_SRA;
            F_SLLV: funct_ctrl = C_SLLV;
            F_SRLV: funct_ctrl = C_SRLV;
            F_SRAV: funct_ctrl = C_SRAV;
`ifdef ALU_OVERFLOW_EN
            F_ADD:  funct_ctrl = C_ADDS;
            F_SUB:  funct_ctrl = C_SUBS;
`else
            F_ADD:  funct_ctrl = C_ADD;
            F_SUB:  funct_ctrl = C_SUB;
`endif
            F_ADDU: funct_ctrl = C_ADD;
            F_SUBU: funct_ctrl = C_SUB;
            F_AND:  funct_ctrl = C_AND;
            F_OR:   funct_ctrl = C_OR;
            F_XOR:  funct_ctrl = C_XOR;
            F_NOR:  funct_ctrl = C_NOR;
            F_SLT:  funct_ctrl = C_SLT;
            F_SLTU: funct_ctrl = C_SLTU;
            default: funct_ctrl = C_ADD;
        endcase
    end

    // Only the two BLTZ selectors are distinguished; everything else is BGEZ.
    always_comb begin
        regimm_ctrl = C_BGEZ;
        case (rt_field)
            RT_BLTZ, RT_BLTZAL: regimm_ctrl = C_BLTZ;
            RT_BGEZ, RT_BGEZAL: regimm_ctrl = C_BGEZ;
            default:            regimm_ctrl = C_BGEZ;
        endcase
    end

    always_comb begin
        ctrl = C_ADD;
        case (alu_op)
            OP_ADD:    ctrl = C_ADD;
            OP_SUB:    ctrl = C_SUB;
            OP_RTYPE:  ctrl = funct_ctrl;
            OP_BNE:    ctrl = C_BNE;
            OP_AND:    ctrl = C_AND;
            OP_OR:     ctrl = C_OR;
            OP_XOR:    ctrl = C_XOR;
            OP_SLT:    ctrl = C_SLT;
            OP_SLTU:   ctrl = C_SLTU;
            OP_BLEZ:   ctrl = C_BLEZ;
            OP_BGTZ:   ctrl = C_BGTZ;
            OP_REGIMM: ctrl = regimm_ctrl;
            OP_LUI:    ctrl = C_LUI;
            default:   ctrl = C_ADD;
        endcase
    end

    assign alu_ctrl = ctrl;

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: decode, 32-bit ALU, branch target adder and delay-slot branch register.
// ALU_OVERFLOW_EN adds the combinational signed-overflow output for ADDS/SUBS.
module alu_exec_unit
    import alu_exec_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [4:0]       rt_field,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       shamt,
    output logic [4:0]       alu_ctrl,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    input  logic [WIDTH-1:0] pc,
    input  logic [15:0]      imm16,
    input  logic             branch,
    input  logic             exec1,
    input  logic             exec2,
    output logic [WIDTH-1:0] branch_address,
    output logic             branch_ctrl
`ifdef ALU_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] add_out;
    logic             a_neg;
    logic             a_is_zero;

    alu_decode u_decode (
        .alu_op   (alu_op),
        .funct    (funct),
        .rt_field (rt_field),
        .alu_ctrl (alu_ctrl)
    );

    assign sum       = a + b;
    assign diff      = a - b;
    assign a_neg     = a[WIDTH-1];
    assign a_is_zero = (a == '0);

    // Branch ops produce 0 when taken so that zero doubles as the take signal.
    always_comb begin
        result = sum;
        case (alu_ctrl)
            C_ADD, C_ADDS: result = sum;
            C_SUB, C_SUBS: result = diff;
            C_AND:  result = a & b;
            C_OR:   result = a | b;
            C_XOR:  result = a ^ b;
            C_NOR:  result = ~(a | b);
            C_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            C_SLTU: result = {{(WIDTH-1){1'b0}}, (a < b)};
            C_SLL:  result = b << shamt;
            C_SRL:  result = b >> shamt;
            C_SRA:  result = $signed(b) >>> shamt;
            C_SLLV: result = b << a[4:0];
            C_SRLV: result = b >> a[4:0];
            C_SRAV: result = $signed(b) >>> a[4:0];
            C_BNE:  result = {{(WIDTH-1){1'b0}}, (a == b)};
            C_BLEZ: result = {{(WIDTH-1){1'b0}}, !(a_neg || a_is_zero)};
            C_BGTZ: result = {{(WIDTH-1){1'b0}}, (a_neg || a_is_zero)};
            C_BLTZ: result = {{(WIDTH-1){1'b0}}, !a_neg};
            C_BGEZ: result = {{(WIDTH-1){1'b0}}, a_neg};
            C_LUI:  result = b << 16;
            default: result = sum;
        endcase
    end

    assign zero = (result == '0);

`ifdef ALU_OVERFLOW_EN
    always_comb begin
        overflow = 1'b0;
        if (alu_ctrl == C_ADDS) begin
            overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        end else if (alu_ctrl == C_SUBS) begin
            overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
        end
    end
`endif

    assign add_out = pc + {{(WIDTH-18){imm16[15]}}, imm16, 2'b00};

    logic             pending_d, pending_q;
    logic [WIDTH-1:0] pending_addr_d, pending_addr_q;
    logic             branch_ctrl_d, branch_ctrl_q;
    logic [WIDTH-1:0] branch_address_d, branch_address_q;

    // exec2 consumes the old pending before exec1 overwrites it in the same edge.
    always_comb begin
        pending_d        = pending_q;
        pending_addr_d   = pending_addr_q;
        branch_ctrl_d    = branch_ctrl_q;
        branch_address_d = branch_address_q;
        if (exec2) begin
            branch_ctrl_d    = pending_q;
            branch_address_d = pending_addr_q;
            pending_d        = 1'b0;
        end
        if (exec1) begin
            pending_d      = branch & zero;
            pending_addr_d = add_out;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q        <= 1'b0;
            pending_addr_q   <= '0;
            branch_ctrl_q    <= 1'b0;
            branch_address_q <= '0;
        end else begin
            pending_q        <= pending_d;
            pending_addr_q   <= pending_addr_d;
            branch_ctrl_q    <= branch_ctrl_d;
            branch_address_q <= branch_address_d;
        end
    end

    assign branch_ctrl    = branch_ctrl_q;
    assign branch_address = branch_address_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: random and directed stimulus checked
// against a behavioural model of the ALU and the delay-slot branch register.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  alu_op = '0;
    logic [5:0]  funct = '0;
    logic [4:0]  rt_field = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [4:0]  shamt = '0;
    logic [4:0]  alu_ctrl;
    logic [31:0] result;
    logic        zero;
    logic [31:0] pc = '0;
    logic [15:0] imm16 = '0;
    logic        branch = 1'b0;
    logic        exec1 = 1'b0;
    logic        exec2 = 1'b0;
    logic [31:0] branch_address;
    logic        branch_ctrl;
`ifdef ALU_OVERFLOW_EN
    logic        overflow;
`endif

    always #5 clk = ~clk;

    alu_exec_unit dut (
        .clk            (clk),
        .reset          (reset),
        .alu_op         (alu_op),
        .funct          (funct),
        .rt_field       (rt_field),
        .a              (a),
        .b              (b),
        .shamt          (shamt),
        .alu_ctrl       (alu_ctrl),
        .result         (result),
        .zero           (zero),
        .pc             (pc),
        .imm16          (imm16),
        .branch         (branch),
        .exec1          (exec1),
        .exec2          (exec2),
        .branch_address (branch_address),
        .branch_ctrl    (branch_ctrl)
`ifdef ALU_OVERFLOW_EN
        ,
        .overflow       (overflow)
`endif
    );

    typedef struct {
        logic [4:0]  c;
        logic [31:0] r;
        logic        z;
        logic        bc;
        logic [31:0] ba;
        logic        ov;
        int          id;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_issued = 0;

    // Architectural view of the branch register after the most recent edge.
    logic        m_pend = 1'b0;
    logic [31:0] m_paddr = '0;
    logic        m_bc = 1'b0;
    logic [31:0] m_ba = '0;

    logic [5:0] flist [15] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
                               6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (txn %0d): got %h expected %h", nm, id, act, exp);
        end
    endtask

    function automatic logic [31:0] notaken(input bit taken);
        return taken ? 32'd0 : 32'd1;
    endfunction

    // Reference: what each (alu_op, funct, rt) instruction means arithmetically.
    function automatic void model(input logic [3:0] op, input logic [5:0] fn, input logic [4:0] rt,
                                  input logic [31:0] x, input logic [31:0] y, input logic [4:0] sh,
                                  output logic [4:0] c, output logic [31:0] r, output logic ov);
        longint sx, sy, wide;
        bit ov_op;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ov_op = 1'b0;
        wide = 0;
        c = 5'd0;
        r = x + y;
        case (op)
            4'd1:  begin c = 5'd1;  r = x - y; end
            4'd2: begin
                case (fn)
                    6'h00: begin c = 5'd8;  r = y << sh; end
                    6'h02: begin c = 5'd9;  r = y >> sh; end
                    6'h03: begin c = 5'd10; r = 32'($signed(y) >>> sh); end
                    6'h04: begin c = 5'd11; r = y << x[4:0]; end
                    6'h06: begin c = 5'd12; r = y >> x[4:0]; end
                    6'h07: begin c = 5'd13; r = 32'($signed(y) >>> x[4:0]); end
`ifdef ALU_OVERFLOW_EN
                    6'h20: begin c = 5'd20; r = x + y; wide = sx + sy; ov_op = 1'b1; end
                    6'h22: begin c = 5'd21; r = x - y; wide = sx - sy; ov_op = 1'b1; end
`else
                    6'h20: begin c = 5'd0;  r = x + y; end
                    6'h22: begin c = 5'd1;  r = x - y; end
`endif
                    6'h21: begin c = 5'd0;  r = x + y; end
                    6'h23: begin c = 5'd1;  r = x - y; end
                    6'h24: begin c = 5'd2;  r = x & y; end
                    6'h25: begin c = 5'd3;  r = x | y; end
                    6'h26: begin c = 5'd4;  r = x ^ y; end
                    6'h27: begin c = 5'd5;  r = ~(x | y); end
                    6'h2A: begin c = 5'd6;  r = (sx < sy) ? 32'd1 : 32'd0; end
                    6'h2B: begin c = 5'd7;  r = (x < y) ? 32'd1 : 32'd0; end
                    default: begin c = 5'd0; r = x + y; end
                endcase
            end
            4'd3:  begin c = 5'd14; r = notaken(x != y); end
            4'd4:  begin c = 5'd2;  r = x & y; end
            4'd5:  begin c = 5'd3;  r = x | y; end
            4'd6:  begin c = 5'd4;  r = x ^ y; end
            4'd7:  begin c = 5'd6;  r = (sx < sy) ? 32'd1 : 32'd0; end
            4'd8:  begin c = 5'd7;  r = (x < y) ? 32'd1 : 32'd0; end
            4'd9:  begin c = 5'd15; r = notaken(sx <= 0); end
            4'd10: begin c = 5'd16; r = notaken(sx > 0); end
            4'd11: begin
                if (rt == 5'b00000 || rt == 5'b10000) begin c = 5'd17; r = notaken(sx < 0); end
                else begin c = 5'd18; r = notaken(sx >= 0); end
            end
            4'd12: begin c = 5'd19; r = {y[15:0], 16'h0000}; end
            default: begin c = 5'd0; r = x + y; end
        endcase
        ov = ov_op && (wide != longint'($signed(r)));
    endfunction

    task automatic issue(input logic [3:0] op, input logic [5:0] fn, input logic [4:0] rt,
                         input logic [31:0] x, input logic [31:0] y, input logic [4:0] sh,
                         input logic [31:0] pcv, input logic [15:0] imm, input logic br,
                         input logic e1, input logic e2);
        exp_t e;
        logic [31:0] target;
        logic np;
        @(posedge clk);
        #1;
        alu_op = op; funct = fn; rt_field = rt; a = x; b = y; shamt = sh;
        pc = pcv; imm16 = imm; branch = br; exec1 = e1; exec2 = e2;
        model(op, fn, rt, x, y, sh, e.c, e.r, e.ov);
        e.z  = (e.r == 32'd0);
        e.bc = m_bc;
        e.ba = m_ba;
        e.id = n_issued;
        n_issued++;
        sb.push_back(e);
        target = pcv + 32'(int'($signed(imm)) * 4);
        np = m_pend;
        if (e2) begin
            m_bc = m_pend;
            m_ba = m_paddr;
            np = 1'b0;
        end
        if (e1) begin
            np = br && e.z;
            m_paddr = target;
        end
        m_pend = np;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("alu_ctrl", e.id, 32'(alu_ctrl), 32'(e.c));
                chk("result", e.id, result, e.r);
                chk("zero", e.id, 32'(zero), 32'(e.z));
                chk("branch_ctrl", e.id, 32'(branch_ctrl), 32'(e.bc));
                chk("branch_address", e.id, branch_address, e.ba);
`ifdef ALU_OVERFLOW_EN
                chk("overflow", e.id, 32'(overflow), 32'(e.ov));
`endif
            end
        end
    end

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'h7FFF_FFFF;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic random_phase(input int n);
        logic [31:0] x, y;
        logic [5:0]  fn;
        for (int i = 0; i < n; i++) begin
            x = rnd_operand();
            y = ($urandom_range(0, 3) == 0) ? x : rnd_operand();
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : flist[$urandom_range(0, 14)];
            issue(4'($urandom_range(0, 15)), fn, 5'($urandom), x, y, 5'($urandom),
                  $urandom, 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end
    endtask

    task automatic drain(input string nm);
        int budget;
        budget = 5;
        while (sb.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        #1;
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: scoreboard still holds %0d entries, expected 0", nm, sb.size());
            sb.delete();
        end
    endtask

    initial begin : stim
        #1;
        chk("reset_branch_ctrl", -1, 32'(branch_ctrl), 32'd0);
        chk("reset_branch_address", -1, branch_address, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        issue(4'd2, 6'h21, 5'd0, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        issue(4'd2, 6'h03, 5'd0, 32'd0, 32'h8000_0000, 5'd4, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        issue(4'd2, 6'h06, 5'd0, 32'd36, 32'h0000_00F0, 5'd0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        issue(4'd7, 6'h00, 5'd0, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        issue(4'd8, 6'h00, 5'd0, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        issue(4'd11, 6'h00, 5'd1, 32'd0, 32'd0, 5'd0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        issue(4'd11, 6'h00, 5'd1, 32'h8000_0000, 32'd0, 5'd0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        issue(4'd11, 6'h00, 5'd16, 32'h8000_0000, 32'd0, 5'd0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        issue(4'd12, 6'h00, 5'd0, 32'd0, 32'h0000_ABCD, 5'd0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        issue(4'd2, 6'h20, 5'd0, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        issue(4'd2, 6'h22, 5'd0, 32'h8000_0000, 32'd1, 5'd0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0);

        // Taken BEQ, delay slot, then observe the redirect clearing.
        issue(4'd1, 6'h00, 5'd0, 32'd5, 32'd5, 5'd0, 32'h100, 16'hFFFF, 1'b1, 1'b1, 1'b0);
        issue(4'd0, 6'h00, 5'd0, 32'd1, 32'd2, 5'd0, 32'h200, 16'h0000, 1'b0, 1'b0, 1'b1);
        issue(4'd0, 6'h00, 5'd0, 32'd1, 32'd2, 5'd0, 32'h104, 16'h0000, 1'b0, 1'b1, 1'b0);
        issue(4'd0, 6'h00, 5'd0, 32'd1, 32'd2, 5'd0, 32'h104, 16'h0000, 1'b0, 1'b0, 1'b1);
        issue(4'd0, 6'h00, 5'd0, 32'd0, 32'd0, 5'd0, 32'h0, 16'h0000, 1'b0, 1'b0, 1'b0);
        // Not-taken BNE followed by its EXEC2.
        issue(4'd3, 6'h00, 5'd0, 32'd7, 32'd7, 5'd0, 32'h300, 16'h0010, 1'b1, 1'b1, 1'b0);
        issue(4'd0, 6'h00, 5'd0, 32'd0, 32'd0, 5'd0, 32'h0, 16'h0000, 1'b0, 1'b0, 1'b1);
        issue(4'd0, 6'h00, 5'd0, 32'd0, 32'd0, 5'd0, 32'h0, 16'h0000, 1'b0, 1'b0, 1'b0);

        random_phase(400);

        // Arm pending on top of an active redirect, then reset mid-branch.
        issue(4'd1, 6'h00, 5'd0, 32'd9, 32'd9, 5'd0, 32'h400, 16'h0004, 1'b1, 1'b1, 1'b0);
        issue(4'd0, 6'h00, 5'd0, 32'd0, 32'd1, 5'd0, 32'h0, 16'h0000, 1'b0, 1'b0, 1'b1);
        issue(4'd1, 6'h00, 5'd0, 32'd3, 32'd3, 5'd0, 32'h500, 16'h0008, 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        exec1 = 1'b0;
        exec2 = 1'b0;
        branch = 1'b0;
        drain("pre_reset_drain");
        chk("pre_reset_branch_ctrl", -2, 32'(branch_ctrl), 32'(m_bc));
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_branch_ctrl", -2, 32'(branch_ctrl), 32'd0);
        chk("async_reset_branch_address", -2, branch_address, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        m_pend = 1'b0; m_paddr = '0; m_bc = 1'b0; m_ba = '0;
        exec2 = 1'b1;
        @(posedge clk);
        #1;
        exec2 = 1'b0;
        chk("post_reset_exec2_branch_ctrl", -3, 32'(branch_ctrl), 32'd0);

        random_phase(60);
        @(posedge clk);
        #1;
        exec1 = 1'b0;
        exec2 = 1'b0;
        drain("final_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage datapath block of the multicycle MIPS core: operation decode, 32-bit integer ALU, and branch target and delay-slot branch register.
- Decodes the control unit's 4-bit ALU opcode, the instruction funct field and the rt field into a 5-bit ALU control code, then computes result and zero.
- Latches taken-branch decisions so the PC mux redirects after the delay-slot instruction.

Parameters:
- WIDTH, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- alu_op  in  4  ALU opcode from control unit
- funct  in  6  instr[5:0]
- rt_field  in  5  instr[20:16]; REGIMM branch selector
- a  in  32  rs operand
- b  in  32  rt operand or zero-extended immediate
- shamt  in  5  instr[10:6]
- alu_ctrl  out  5  decoded operation (exported for debug)
- result  out  32  ALU result
- zero  out  1  high when result==0
- pc  in  32  current PC (address of the branch instruction)
- imm16  in  16  instr[15:0]
- branch  in  1  instruction is a conditional branch
- exec1  in  1  FSM in EXEC1
- exec2  in  1  FSM in EXEC2
- branch_address  out  32  latched target base
- branch_ctrl  out  1  redirect PC with branch_address this instruction

Behaviour:
- Decode is combinational.
- alu_op encoding:
  - 0 ADD
  - 1 SUB (BEQ)
  - 2 R-type via funct
  - 3 BNE
  - 4 AND
  - 5 OR
  - 6 XOR
  - 7 SLT
  - 8 SLTU
  - 9 BLEZ
  - 10 BGTZ
  - 11 REGIMM via rt_field
  - 12 LUI
  - 13–15 map to ADD
- funct decode: 0x00 SLL, 0x02 SRL, 0x03 SRA, 0x04 SLLV, 0x06 SRLV, 0x07 SRAV, 0x20/0x21 ADD, 0x22/0x23 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT, 0x2B SLTU; all other funct values map to ADD.
- rt_field decode: 00000/10000 → BLTZ; 00001/10001 → BGEZ; any other value → BGEZ.
- alu_ctrl codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR
  - 6 SLT, 7 SLTU
  - 8 SLL, 9 SRL, 10 SRA, 11 SLLV, 12 SRLV, 13 SRAV
  - 14 BNE, 15 BLEZ, 16 BGTZ, 17 BLTZ, 18 BGEZ
  - 19 LUI
- Arithmetic:
  - ADD and SUB wrap modulo 2^32 with no trap.
  - SLT is signed and SLTU unsigned; both return 0 or 1.
  - Constant shifts shift b by shamt. Variable shifts shift b by a[4:0]. SRA/SRAV replicate b[31].
  - LUI returns b<<16.
- Branch tests return 0 when the branch is taken, else 1:
  - BNE: a!=b
  - BLEZ: signed a<=0
  - BGTZ: signed a>0
  - BLTZ: signed a<0
  - BGEZ: signed a>=0
  - BEQ uses SUB, so result is 0 when a==b.
- zero = (result==0) for every op.
- Branch target: add_out = pc + (sign_extend(imm16)<<2), computed combinationally.
- Registered state: pending, pending_addr, branch_ctrl, branch_address. All clear to 0 asynchronously while reset is low.
- On each rising edge:
  - If exec1: pending <= branch & zero; pending_addr <= add_out.
  - If exec2: branch_ctrl <= pending; branch_address <= pending_addr; pending <= 0.
- Resulting timing: branch_ctrl rises at the taken branch's EXEC2 edge and stays high for the entire following (delay-slot) instruction. At that instruction's EXEC2 edge it reloads, to 0 unless that instruction was itself a taken branch.
- A not-taken branch leaves branch_ctrl 0 after its EXEC2.
- exec1 and exec2 high together: both updates apply in the same edge. The exec2 transfer uses the old pending; the new pending value comes from exec1.
- Reset asserted mid-branch discards pending and armed state.

Optional Feature:
- Macro ALU_OVERFLOW_EN.
- Defined:
  - Adds output port overflow (1 bit, combinational).
  - funct 0x20 decodes to ADDS (code 20) and 0x22 to SUBS (code 21). Each computes as ADD/SUB; overflow is high on signed two's-complement overflow.
  - overflow is 0 for every other op.
- Undefined: the port is absent, and 0x20/0x22 decode to ADD/SUB.

Decomposition:
- Package alu_exec_pkg holds:
  - alu_op enum
  - alu_ctrl enum
  - funct constants
  - REGIMM rt constants
- One combinational sub-module, alu_decode (alu_op, funct, rt_field → alu_ctrl).
- The ALU datapath and branch register stay in the top.

Test Plan:
- alu_op=2, funct=0x21, a=0xFFFFFFFF, b=1 → result 0, zero=1.
- alu_op=2, funct=0x03, b=0x80000000, shamt=4 → result 0xF8000000; funct=0x06, a=36, b=0xF0 → result 0x0F.
- alu_op=7, a=0xFFFFFFFF, b=1 → result 1; alu_op=8 with same operands → result 0.
- alu_op=11, rt_field=00001, a=0 → zero=1; a=0x80000000 → zero=0.
- pc=0x100, imm16=0xFFFF, branch=1, BEQ with a==b; pulse exec1 then exec2 → branch_address=0xFC, branch_ctrl=1. Next exec1 (branch=0) then exec2 → branch_ctrl=0.
- Assert reset low while pending=1 → branch_ctrl and branch_address read 0 immediately. A following exec2 edge leaves branch_ctrl=0.
